// File: rtl/uc_pkg.sv
// Shared definitions for the unidade_controle control unit: FSM states,
// opcode constants and instruction field positions.
package uc_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int INSTR_W  = 16;

  typedef enum logic [1:0] {
    BUSCA      = 2'd0,
    DECODIFICA = 2'd1,
    EXECUTA    = 2'd2,
    PARADO     = 2'd3
  } estado_t;

  localparam logic [3:0] OP_ULA_MAX = 4'b1011;
  localparam logic [3:0] OP_DIV     = 4'b0100;
  localparam logic [3:0] OP_LDI     = 4'b1100;
  localparam logic [3:0] OP_JMP     = 4'b1101;
  localparam logic [3:0] OP_HALT    = 4'b1110;
  localparam logic [3:0] OP_NOP     = 4'b1111;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int RT_HI  = 7;
  localparam int RT_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  function automatic logic eh_op_ula(input logic [3:0] op);
    return op <= OP_ULA_MAX;
  endfunction

endpackage

// File: rtl/banco_registradores.sv
// 4x8 register bank: two combinational operand reads, one debug read,
// one synchronous write port; all registers clear on reset.
module banco_registradores
  import uc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [1:0]        raddr_dbg,
  output logic [DATA_W-1:0] rdata_dbg
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Reads see the pre-write value, so rd==rs reads the old contents.
  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle fetch/decode/execute control unit for the 8-bit CPU.
// Optional feature macro: UC_DIV0_TRAP_EN (trap on DIV by zero).
//
// state      | meaning
// BUSCA      | mem_req high, wait for mem_ack, latch instruction, pc+1
// DECODIFICA | load ALU operands, or finish LDI/JMP/NOP/HALT
// EXECUTA    | write ALU result to R[rd]
// PARADO     | halted until reset
module unidade_controle
  import uc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  output logic [3:0]        ula_opcode,
  input  logic [DATA_W-1:0] ula_resultado,
  input  logic [1:0]        reg_sel,
  output logic [DATA_W-1:0] reg_dado,
  output logic              parado,
  output logic              erro
);

  estado_t              estado_q, estado_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 mem_req_q, mem_req_d;
  logic [DATA_W-1:0]    ula_a_q, ula_a_d;
  logic [DATA_W-1:0]    ula_b_q, ula_b_d;
  logic [3:0]           ula_opcode_q, ula_opcode_d;
  logic                 parado_q, parado_d;
  logic                 erro_q, erro_d;

  logic [3:0]           op;
  logic [1:0]           rd, rs, rt;
  logic [DATA_W-1:0]    imm;
  logic                 we;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W-1:0]    rdata_a, rdata_b;
  logic                 div0;

  assign op  = instr_q[OP_HI:OP_LO];
  assign rd  = instr_q[RD_HI:RD_LO];
  assign rs  = instr_q[RS_HI:RS_LO];
  assign rt  = instr_q[RT_HI:RT_LO];
  assign imm = instr_q[IMM_HI:IMM_LO];

  banco_registradores u_banco (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (rd),
    .wdata     (wdata),
    .raddr_a   (rs),
    .rdata_a   (rdata_a),
    .raddr_b   (rt),
    .rdata_b   (rdata_b),
    .raddr_dbg (reg_sel),
    .rdata_dbg (reg_dado)
  );

`ifdef UC_DIV0_TRAP_EN
  assign div0 = (ula_opcode_q == OP_DIV) && (ula_b_q == '0);
`else
  assign div0 = 1'b0;
`endif

  always_comb begin
    estado_d     = estado_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    mem_req_d    = 1'b0;
    ula_a_d      = ula_a_q;
    ula_b_d      = ula_b_q;
    ula_opcode_d = ula_opcode_q;
    parado_d     = parado_q;
    erro_d       = erro_q;
    we           = 1'b0;
    wdata        = ula_resultado;

    case (estado_q)
      BUSCA: begin
        // An ack only counts while a request is actually on the bus.
        if (mem_req_q && mem_ack) begin
          instr_d  = mem_instr;
          pc_d     = pc_q + PC_W'(1);
          estado_d = DECODIFICA;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      DECODIFICA: begin
        if (eh_op_ula(op)) begin
          ula_a_d      = rdata_a;
          ula_b_d      = rdata_b;
          ula_opcode_d = op;
          estado_d     = EXECUTA;
        end else begin
          estado_d  = BUSCA;
          mem_req_d = 1'b1;
          case (op)
            OP_LDI: begin
              we    = 1'b1;
              wdata = imm;
            end
            OP_JMP:  pc_d = PC_W'(imm);
            OP_HALT: begin
              estado_d  = PARADO;
              parado_d  = 1'b1;
              mem_req_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      EXECUTA: begin
        if (div0) begin
          erro_d   = 1'b1;
          parado_d = 1'b1;
          estado_d = PARADO;
        end else begin
          we        = 1'b1;
          mem_req_d = 1'b1;
          estado_d  = BUSCA;
        end
      end
      PARADO:  ;
      default: estado_d = BUSCA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q     <= BUSCA;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      mem_req_q    <= 1'b0;
      ula_a_q      <= '0;
      ula_b_q      <= '0;
      ula_opcode_q <= '0;
      parado_q     <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      mem_req_q    <= mem_req_d;
      ula_a_q      <= ula_a_d;
      ula_b_q      <= ula_b_d;
      ula_opcode_q <= ula_opcode_d;
      parado_q     <= parado_d;
      erro_q       <= erro_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = pc_q;
  assign ula_a      = ula_a_q;
  assign ula_b      = ula_b_q;
  assign ula_opcode = ula_opcode_q;
  assign parado     = parado_q;
  assign erro       = erro_q;

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle fetch/decode/execute control unit for the 8-bit CPU. It fetches 16-bit instructions from instruction memory over a req/ack handshake and decodes them. It holds a 4×8 register bank and drives the ALU operands and opcode directly (ula_a/ula_b/ula_opcode are the ALU's `a`/`b`/`opcode`). It writes the ALU result (`saidaULA`) back into the bank. It sits directly upstream of the ALU and consumes its output.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- RESET_PC, 8'h00, PC value after reset

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- mem_req  out  1  instruction fetch request
- mem_addr  out  PC_W  fetch address (current PC)
- mem_ack  in  1  instruction valid this cycle
- mem_instr  in  16  instruction word, sampled when mem_ack=1
- ula_a  out  8  ALU operand a
- ula_b  out  8  ALU operand b
- ula_opcode  out  4  ALU opcode
- ula_resultado  in  8  ALU result (combinational from ula_a/b/opcode)
- reg_sel  in  2  debug register select
- reg_dado  out  8  debug read of R[reg_sel], combinational
- parado  out  1  core halted
- erro  out  1  trap flag (see Configuration)

## Operation
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [7:0] imm.
- op 0000–1011: ALU op; ula_a=R[rs], ula_b=R[rt], ula_opcode=op; R[rd] <= ula_resultado.
- op 1100 LDI: R[rd] <= imm; ALU not used.
- op 1101 JMP: pc <= imm[PC_W-1:0].
- op 1110 HALT: enter PARADO, parado=1 until reset.
- op 1111 NOP.
- FSM states:
  - BUSCA: mem_req=1, mem_addr=pc; stay until mem_ack; on ack latch instr, pc <= pc+1 (wraps 255→0) → DECODIFICA.
  - DECODIFICA: register ula_a/ula_b/ula_opcode from bank (ALU ops only); LDI/JMP/NOP/HALT complete here → BUSCA (HALT → PARADO).
  - EXECUTA: write ula_resultado to R[rd] → BUSCA.
  - PARADO: absorbing.
- Register bank: synchronous write, combinational read; rd==rs is allowed, and the read returns the old value.
- mem_ack outside BUSCA is ignored. mem_req deasserts the cycle after ack.
- ula_a/ula_b/ula_opcode hold their last values outside DECODIFICA updates. Default opcode is 4'b0000, which gives ALU output 0.

## Timing
- Reset values: pc=RESET_PC, all R=0, state=BUSCA, mem_req=0 in the reset cycle and 1 from the first cycle after, ula_a=ula_b=0, ula_opcode=0, parado=0, erro=0.
- ALU instruction: BUSCA (≥1 cycle, ends on ack) + DECODIFICA (1) + EXECUTA (1). With zero-wait ack, that is 3 cycles. The written value is visible on reg_dado in the cycle after EXECUTA.
- LDI/JMP/NOP: 2 cycles with zero-wait ack.
- rst asserted in any state, including mid-fetch or EXECUTA, aborts at the next edge. No writeback occurs, and all state returns to reset values.
- mem_ack arriving in the same cycle as rst is ignored.

## Configuration
- UC_DIV0_TRAP_EN defined: for op 0100 with ula_b==0 in EXECUTA, R[rd] is not written, erro=1, and the state goes to PARADO (parado=1).
- UC_DIV0_TRAP_EN undefined: division is written back as-is from ula_resultado, and erro is tied 0.

## Structure
- Package uc_pkg holds:
  - the state encoding (BUSCA, DECODIFICA, EXECUTA, PARADO);
  - opcode constants (OP_DIV=4'b0100, OP_LDI, OP_JMP, OP_HALT, OP_NOP);
  - instruction field bit positions.
- One sub-module, banco_registradores: 4×8, two combinational read ports plus one debug read port, one synchronous write port, reset to 0.

## Test plan
- Reset, then LDI R1,5; LDI R2,3; ADD(0001) R0,R1,R2 with zero-wait ack → reg_dado(R0)=8'h08. mem_addr sequence is 0,1,2.
- SUB R3,R2,R1 with R2=3, R1=5 → R3=8'hFE (8-bit wrap). With mem_ack delayed 4 cycles, mem_req is held and mem_addr is stable for those cycles.
- JMP 8'hFF, then NOP at address FF → the next fetch address is 8'h00 (pc wrap).
- DIV with R2=0:
  - with UC_DIV0_TRAP_EN: R0 unchanged, erro=1, parado=1, mem_req stays 0;
  - without it: R0=ula_resultado, erro=0, fetching continues.
- Assert rst during EXECUTA of ADD → R[rd] stays 0, pc=RESET_PC, mem_req=1 the cycle after rst falls.
- HALT → parado=1, no further mem_req for 20 cycles; a mem_ack pulse is ignored.
